// File: rtl/rvfi_retire_buffer.sv
// Multi-lane RVFI retire buffer: compacts up to NRET retirements per cycle,
// stamps each with a 64-bit rvfi order number and drains one record per cycle.
module rvfi_retire_buffer #(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  localparam int REC_W = 32 + 15 + 8 * XLEN + XLEN / 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NRET-1:0]           in_valid,
  input  logic [NRET*REC_W-1:0]     in_rec,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REC_W-1:0]          out_rec,
  output logic [63:0]               out_order,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW       = $clog2(DEPTH);
  localparam int CW       = PW + 1;
  localparam int RD_A_LSB = 42 + 2 * XLEN;
  localparam int RD_W_LSB = 47 + 2 * XLEN;

  // Handshakes: a beat is taken when in_ready=1 (in_ready never looks at
  // in_valid); a record leaves when out_valid && out_ready, and out_rec /
  // out_order hold steady while out_valid=1 && out_ready=0.

  logic [CW-1:0]    count_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [63:0]      ord_q;
  logic             overflow_q;

  logic [REC_W-1:0] rec_mem [DEPTH];
  logic [63:0]      ord_mem [DEPTH];

  logic [CW-1:0]    n_valid;
  logic [CW-1:0]    lane_off [NRET];
  logic [PW-1:0]    slot     [NRET];
  logic [REC_W-1:0] norm_rec [NRET];
  logic [CW-1:0]    pushed;
  logic             push;
  logic             drop;
  logic             pop;

  assign in_ready  = (count_q <= CW'(DEPTH - NRET));
  assign out_valid = (count_q != '0);
  assign push      = in_ready && (|in_valid);
  assign drop      = !in_ready && (|in_valid);
  assign pop       = out_valid && out_ready;
  assign pushed    = push ? n_valid : '0;

  assign out_rec   = out_valid ? rec_mem[rd_ptr] : '0;
  assign out_order = out_valid ? ord_mem[rd_ptr] : '0;
  assign overflow  = overflow_q;
  assign count     = count_q;

  // Lane i lands at wr_ptr + (number of valid lanes below i), which packs
  // sparse beats into consecutive slots.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NRET; i++) begin
      lane_off[i] = n_valid;
      slot[i]     = wr_ptr + lane_off[i][PW-1:0];
      n_valid     = n_valid + CW'(in_valid[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      norm_rec[i] = in_rec[i*REC_W +: REC_W];
      if (norm_rec[i][RD_A_LSB +: 5] == 5'd0)
        norm_rec[i][RD_W_LSB +: XLEN] = '0;
    end
  end

  // Storage carries no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int i = 0; i < NRET; i++) begin
        if (in_valid[i]) begin
          rec_mem[slot[i]] <= norm_rec[i];
          ord_mem[slot[i]] <= ord_q + 64'(lane_off[i]);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ord_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + n_valid[PW-1:0];
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      // Dropped beats still consume order numbers so the checker sees the gap.
      ord_q   <= ord_q + 64'(n_valid);
      count_q <= count_q + pushed - CW'(pop);
      if (drop)
        overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Directed bench for rvfi_retire_buffer (NRET=2, XLEN=32, DEPTH=8) with a
// queue-based scoreboard checked after every clock.
module tb_rvfi_retire_buffer;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int W     = 307;

  logic              clock;
  logic              reset;
  logic [NRET-1:0]   in_valid;
  logic [NRET*W-1:0] in_rec;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_rec;
  logic [63:0]       out_order;
  logic              overflow;
  logic [3:0]        count;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]  exp_q[$];
  logic [63:0]   ord_q[$];
  logic [63:0]   m_ord;
  logic          m_ovf;

  rvfi_retire_buffer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_rec    (in_rec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rec   (out_rec),
    .out_order (out_order),
    .overflow  (overflow),
    .count     (count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] insn, input logic [4:0] rd,
                                      input logic [31:0] rdw, input logic [31:0] pc);
    logic [W-1:0] r;
    r          = '0;
    r[31:0]    = insn;
    r[36:32]   = 5'd1;
    r[41:37]   = 5'd2;
    r[73:42]   = insn ^ 32'h1111_1111;
    r[105:74]  = ~insn;
    r[110:106] = rd;
    r[142:111] = rdw;
    r[174:143] = pc;
    r[206:175] = pc + 32'd4;
    r[238:207] = pc ^ 32'h0F0F_0000;
    r[242:239] = 4'hA;
    r[274:243] = insn + 32'd1;
    r[306:275] = insn - 32'd1;
    return r;
  endfunction

  function automatic logic [W-1:0] norm(input logic [W-1:0] r);
    logic [W-1:0] n;
    n = r;
    if (n[110:106] == 5'd0) n[142:111] = 32'd0;
    return n;
  endfunction

  // scoreboard: compare every visible output with the model
  task automatic sb_check();
    check("sb_count",    W'(count),     W'(exp_q.size()));
    check("sb_out_valid", W'(out_valid), W'(exp_q.size() != 0));
    check("sb_in_ready", W'(in_ready),  W'((DEPTH - exp_q.size()) >= NRET));
    check("sb_overflow", W'(overflow),  W'(m_ovf));
    check("sb_out_order", W'(out_order), (exp_q.size() != 0) ? W'(ord_q[0]) : '0);
    check("sb_out_rec",  out_rec,       (exp_q.size() != 0) ? exp_q[0] : '0);
  endtask

  // driver: one clock with the given lanes and sink ready
  task automatic drive(input logic [1:0] v, input logic [W-1:0] r0, input logic [W-1:0] r1,
                       input logic rdy);
    logic [W-1:0] lane [2];
    logic         m_ready;
    int           k;
    lane[0]   = r0;
    lane[1]   = r1;
    in_valid  = v;
    in_rec    = {r1, r0};
    out_ready = rdy;
    m_ready   = (DEPTH - exp_q.size()) >= NRET;
    if (rdy && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      void'(ord_q.pop_front());
    end
    k = 0;
    for (int i = 0; i < NRET; i++) begin
      if (v[i]) begin
        if (m_ready) begin
          exp_q.push_back(norm(lane[i]));
          ord_q.push_back(m_ord + 64'(k));
        end
        k++;
      end
    end
    if (v != 2'b00 && !m_ready) m_ovf = 1'b1;
    m_ord = m_ord + 64'(k);
    @(posedge clock);
    #1;
    in_valid  = '0;
    out_ready = 1'b0;
    sb_check();
  endtask

  task automatic do_reset();
    #1;
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_count",     W'(count),     '0);
    check("rst_overflow",  W'(overflow),  '0);
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_rec",   out_rec,       '0);
    check("rst_out_order", W'(out_order), '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    ord_q.delete();
    m_ord = '0;
    m_ovf = 1'b0;
  endtask

  logic [W-1:0] ra, rb, rx, ry, junk;

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_rec    = '0;
    out_ready = 1'b0;
    m_ord     = '0;
    m_ovf     = 1'b0;
    junk      = mk(32'hFFFF_FFFF, 5'd9, 32'h0BAD_0BAD, 32'h0000_0BAD);
    @(posedge clock);
    #1;
    check("init_count",    W'(count),     '0);
    check("init_out_valid", W'(out_valid), '0);
    check("init_in_ready", W'(in_ready),  W'(1));
    check("init_out_rec",  out_rec,       '0);
    reset = 1'b0;

    // two lanes in one beat, drained on consecutive ready cycles
    ra = mk(32'h0000_0013, 5'd0, 32'h0, 32'h8000_0000);
    rb = mk(32'h0010_0093, 5'd1, 32'h1, 32'h8000_0004);
    drive(2'b11, ra, rb, 1'b0);
    check("t1_count2", W'(count), W'(2));
    check("t1_order0", W'(out_order), '0);
    check("t1_insn0",  W'(out_rec[31:0]), W'(32'h0000_0013));
    drive(2'b00, '0, '0, 1'b1);
    check("t1_count1", W'(count), W'(1));
    check("t1_order1", W'(out_order), W'(1));
    check("t1_insn1",  W'(out_rec[31:0]), W'(32'h0010_0093));
    drive(2'b00, '0, '0, 1'b1);
    check("t1_count0", W'(count), '0);
    drive(2'b00, '0, '0, 1'b1);
    check("t1_empty_pop", W'(count), '0);

    // sparse lanes are packed with no holes
    do_reset();
    drive(2'b10, junk, mk(32'h0000_0033, 5'd3, 32'h3, 32'h8000_0004), 1'b0);
    drive(2'b01, mk(32'h0000_0073, 5'd4, 32'h4, 32'h8000_0008), junk, 1'b0);
    check("t2_count", W'(count), W'(2));
    check("t2_pc0",   W'(out_rec[174:143]), W'(32'h8000_0004));
    check("t2_ord0",  W'(out_order), '0);
    drive(2'b00, '0, '0, 1'b1);
    check("t2_pc1",   W'(out_rec[174:143]), W'(32'h8000_0008));
    check("t2_ord1",  W'(out_order), W'(1));
    drive(2'b00, '0, '0, 1'b1);

    // rd_wdata cleared only when rd_addr is x0
    drive(2'b11, mk(32'h0000_1013, 5'd0, 32'hDEAD_BEEF, 32'h8000_0010),
          mk(32'h0000_2013, 5'd5, 32'hDEAD_BEEF, 32'h8000_0014), 1'b0);
    check("t3_rd0_wdata", W'(out_rec[142:111]), '0);
    drive(2'b00, '0, '0, 1'b1);
    check("t3_rd5_wdata", W'(out_rec[142:111]), W'(32'hDEAD_BEEF));
    drive(2'b00, '0, '0, 1'b1);

    // fill with the sink stalled, drop one beat, drain, check order gap
    do_reset();
    for (int b = 0; b < 4; b++)
      drive(2'b11, mk(32'h100 + 32'(2*b), 5'd1, 32'(b), 32'h9000_0000 + 32'(8*b)),
            mk(32'h101 + 32'(2*b), 5'd2, 32'(b), 32'h9000_0004 + 32'(8*b)), 1'b0);
    check("t4_full_count", W'(count), W'(8));
    check("t4_full_ready", W'(in_ready), '0);
    check("t4_no_ovf_yet", W'(overflow), '0);
    drive(2'b11, junk, junk, 1'b0);
    check("t4_drop_count", W'(count), W'(8));
    check("t4_overflow",   W'(overflow), W'(1));
    for (int p = 0; p < 8; p++) drive(2'b00, '0, '0, 1'b1);
    drive(2'b11, mk(32'h0000_0213, 5'd6, 32'h6, 32'hA000_0000),
          mk(32'h0000_0313, 5'd7, 32'h7, 32'hA000_0004), 1'b0);
    check("t4_order10", W'(out_order), W'(10));
    check("t4_ovf_sticky", W'(overflow), W'(1));
    drive(2'b00, '0, '0, 1'b1);
    check("t4_order11", W'(out_order), W'(11));
    drive(2'b00, '0, '0, 1'b1);

    // simultaneous push and pop, beat straddling slot 7 -> 0
    do_reset();
    for (int b = 0; b < 3; b++)
      drive(2'b11, mk(32'h400 + 32'(b), 5'd1, 32'h1, 32'(16*b)),
            mk(32'h480 + 32'(b), 5'd1, 32'h1, 32'(16*b + 4)), 1'b0);
    drive(2'b01, mk(32'h0000_0500, 5'd2, 32'h2, 32'h0000_0100), junk, 1'b0);
    for (int p = 0; p < 4; p++) drive(2'b00, '0, '0, 1'b1);
    check("t5_count3", W'(count), W'(3));
    rx = mk(32'h0000_0600, 5'd3, 32'h3, 32'h0000_0200);
    ry = mk(32'h0000_0700, 5'd4, 32'h4, 32'h0000_0204);
    drive(2'b11, rx, ry, 1'b1);
    check("t5_count4", W'(count), W'(4));
    check("t5_head_ord", W'(out_order), W'(5));
    drive(2'b00, '0, '0, 1'b1);
    drive(2'b00, '0, '0, 1'b1);
    check("t5_wrap_ord7", W'(out_order), W'(7));
    check("t5_wrap_rec7", out_rec, rx);
    drive(2'b00, '0, '0, 1'b1);
    check("t5_wrap_ord8", W'(out_order), W'(8));
    check("t5_wrap_rec8", out_rec, ry);
    drive(2'b00, '0, '0, 1'b1);

    // reset mid-stream discards contents and order state
    do_reset();
    for (int b = 0; b < 5; b++) drive(2'b11, mk(32'h800 + 32'(b), 5'd1, 32'h1, 32'(b)),
                                      mk(32'h900 + 32'(b), 5'd1, 32'h1, 32'(b)), 1'b0);
    for (int p = 0; p < 3; p++) drive(2'b00, '0, '0, 1'b1);
    check("t6_count5",  W'(count), W'(5));
    check("t6_ovf",     W'(overflow), W'(1));
    do_reset();
    drive(2'b01, mk(32'h0000_0A13, 5'd8, 32'h8, 32'hB000_0000), junk, 1'b0);
    check("t6_order0",  W'(out_order), '0);
    check("t6_count1",  W'(count), W'(1));
    drive(2'b00, '0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_buffer.md
# rvfi_retire_buffer

Parametrised successor to the single-lane RVFI tracer. It accepts up to NRET retirement records per cycle from the core's retire stage and compacts the valid lanes in lane order. Each record is stamped with a monotonically increasing 64-bit rvfi order number and stored in a DEPTH-entry FIFO. Records drain one per cycle to the formal checker or trace sink over a valid/ready handshake, and a sticky overflow flag reports any dropped retirements.

## Interface
- NRET, 2: retirement lanes per cycle, 1..4.
- XLEN, 32: register and address width, 32 or 64.
- DEPTH, 8: FIFO entries; power of two, >= 2*NRET.
- REC_W (localparam) = 32+15+8*XLEN+XLEN/8, which is 307 at XLEN=32.
- clock  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  NRET  per-lane retire strobe; lanes may be sparse, e.g. 2'b10.
- in_rec  in  NRET*REC_W  lane i record at [i*REC_W +: REC_W].
- in_ready  out  1  buffer can take a full NRET-lane beat this cycle.
- out_valid  out  1  out_rec/out_order hold a record.
- out_ready  in  1  sink accepts the record.
- out_rec  out  REC_W  record; 0 while out_valid=0.
- out_order  out  64  rvfi_order of the record; 0 while out_valid=0.
- overflow  out  1  sticky; a retirement was dropped since reset.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Record layout, LSB first:
  - insn 32, rs1_addr 5, rs2_addr 5, rs1_rdata XLEN, rs2_rdata XLEN;
  - rd_addr 5, rd_wdata XLEN, pc_rdata XLEN, pc_wdata XLEN;
  - mem_addr XLEN, mem_wmask XLEN/8, mem_rdata XLEN, mem_wdata XLEN.
- Normalisation on push: if rd_addr==0 then rd_wdata is stored as 0. All other fields are stored verbatim.
- Beat accepted when in_ready=1. The valid lanes are written in ascending lane index to consecutive FIFO slots starting at wr_ptr. wr_ptr advances by popcount(in_valid) modulo DEPTH.
- Order numbering:
  - Internal 64-bit counter ord.
  - The k-th valid lane (k=0..) of a beat gets order ord+k; ord advances by popcount(in_valid).
  - ord wraps modulo 2^64.
- Drop: in_valid!=0 while in_ready=0.
  - No FIFO write.
  - ord still advances by popcount(in_valid), so the checker sees order gaps.
  - overflow is set to 1 and stays set until reset.
- Pop: out_valid && out_ready. rd_ptr advances by 1 modulo DEPTH.
- Occupancy: count_next = count + pushed - popped. Simultaneous push and pop in the same cycle is legal.
- in_ready = (DEPTH - count) >= NRET, computed from the registered count only. A same-cycle pop does not raise in_ready.
- out_valid = (count != 0). The head entry is presented from the storage read at rd_ptr.

## Timing
- Reset (async assert, sync-safe release):
  - count=0, wr_ptr=rd_ptr=0, ord=0, overflow=0;
  - out_valid=0, out_rec=0, out_order=0, in_ready=1.
- Reset mid-operation discards all stored records immediately. There is no drain.
- Latency: a record accepted at edge N is visible on out_valid no earlier than after edge N, i.e. in cycle N+1. There is no combinational in-to-out bypass.
- Throughput: push up to NRET per cycle, pop 1 per cycle. Sustained NRET>1 input without stalls fills the FIFO.
- out_rec/out_order are stable while out_valid=1 && out_ready=0. The sink may hold out_ready low indefinitely.
- Full: count > DEPTH-NRET forces in_ready=0, even if only one lane is valid.
- Empty: out_valid=0. A pop request with out_ready=1 has no effect.
- Pointer wrap: a beat straddling slot DEPTH-1 continues at slot 0.

## Test plan
- Single beat, lanes 2'b11, NRET=2, insn 0x00000013 and 0x00100093 → next cycle out_order=0 then 1 on consecutive out_ready=1 cycles, count 2→1→0.
- Sparse lanes 2'b10 carrying pc_rdata=0x80000004, then 2'b01 carrying 0x80000008 → out_order 0,1 in that pc order; no empty slots emitted.
- rd_addr=0 with rd_wdata=0xDEADBEEF → out_rec rd_wdata field reads 0x00000000.
- Hold out_ready=0 and push 2'b11 each cycle with DEPTH=8:
  - in_ready falls after 4 beats (count=8);
  - the 5th beat is dropped and overflow=1;
  - after draining, the next push carries out_order=10 (8 stored + 2 dropped).
- Push 2'b11 and pop in the same cycle with count=3 → count=4; wr_ptr wrap from slot 7 to 0 preserves record order.
- Assert reset mid-stream with count=5 and overflow=1 → in the same cycle out_valid=0, count=0, overflow=0, in_ready=1; the next accepted record has out_order=0.
